// File: rtl/cnn_layer_accel_fas_dout_wr.sv
// FAS output write channel: buffers dout beats and issues fixed-length write bursts.
// Optional ReLU on incoming words is enabled by defining CNN_LAYER_ACCEL_FAS_WR_RELU_EN.
module cnn_layer_accel_fas_dout_wr #(
  parameter int C_FAS_ID     = 0,
  parameter int C_SM_WR_ID   = 0,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_BURST_LEN  = 16,
  parameter int C_FIFO_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [C_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [23:0]             cfg_num_words,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [C_DATA_WIDTH-1:0] din,
  output logic                    wr_req,
  input  logic                    wr_req_ack,
  output logic [3:0]              wr_req_id,
  output logic [3:0]              wr_req_fas_id,
  output logic [C_ADDR_WIDTH-1:0] wr_req_addr,
  output logic [8:0]              wr_req_len,
  output logic                    wr_data_valid,
  input  logic                    wr_data_ready,
  output logic [C_DATA_WIDTH-1:0] wr_data,
  output logic                    wr_data_last,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(C_FIFO_DEPTH);
  localparam logic [C_ADDR_WIDTH-1:0] BYTES =
    C_ADDR_WIDTH'(C_DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_REQ,
    S_DATA,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [23:0]             rem_q, rem_d;
  logic [23:0]             in_rem_q, in_rem_d;
  logic [8:0]              beat_q, beat_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [C_DATA_WIDTH-1:0] mem_q [C_FIFO_DEPTH];

  logic [8:0]              burst;
  logic [C_DATA_WIDTH-1:0] din_w;
  logic                    active;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    buf_ok;

`ifdef CNN_LAYER_ACCEL_FAS_WR_RELU_EN
  // Negative words are clamped to zero on the way into the FIFO.
  always_comb begin
    din_w = din;
    if (din[C_DATA_WIDTH-1]) din_w = '0;
  end
`else
  assign din_w = din;
`endif

  // Current burst length: full burst or whatever remains.
  always_comb begin
    burst = 9'(C_BURST_LEN);
    if (rem_q < 24'(C_BURST_LEN)) burst = rem_q[8:0];
  end

  assign active     = (state_q == S_FILL) ||
                      (state_q == S_REQ)  ||
                      (state_q == S_DATA);
  assign fifo_full  = (cnt_q == FULL);
  assign fifo_empty = (cnt_q == '0);
  assign buf_ok     = ({{(16-CW){1'b0}}, cnt_q} >= {7'd0, burst});

  assign cfg_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign din_ready     = active && !fifo_full && (in_rem_q != '0);
  assign push          = din_valid && din_ready;
  assign wr_req        = (state_q == S_REQ);
  assign wr_req_id     = 4'(C_SM_WR_ID);
  assign wr_req_fas_id = 4'(C_FAS_ID);
  assign wr_req_addr   = wr_req ? addr_q : '0;
  assign wr_req_len    = wr_req ? burst : '0;
  assign wr_data_valid = (state_q == S_DATA) && !fifo_empty;
  assign wr_data       = wr_data_valid ? mem_q[rd_ptr_q] : '0;
  assign wr_data_last  = (state_q == S_DATA) && (beat_q == 9'd1);
  assign pop           = wr_data_valid && wr_data_ready;

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Burst sequencing: fill, request, stream data, repeat until done.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    in_rem_d = in_rem_q;
    beat_d   = beat_q;
    if (push) in_rem_d = in_rem_q - 24'd1;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          addr_d   = cfg_base_addr;
          rem_d    = cfg_num_words;
          in_rem_d = cfg_num_words;
          state_d  = (cfg_num_words == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (buf_ok) state_d = S_REQ;
      end
      S_REQ: begin
        if (wr_req_ack) begin
          beat_d  = burst;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (pop) begin
          beat_d = beat_q - 9'd1;
          if (beat_q == 9'd1) begin
            addr_d  = addr_q + C_ADDR_WIDTH'(burst) * BYTES;
            rem_d   = rem_q - 24'(burst);
            state_d = (rem_q == 24'(burst)) ? S_DONE : S_FILL;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and FIFO bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      in_rem_q <= '0;
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      in_rem_q <= in_rem_d;
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din_w;
  end

endmodule

// File: tb/tb_cnn_layer_accel_fas_dout_wr.sv
// Bench for cnn_layer_accel_fas_dout_wr: directed and random streams
// compared against a burst-splitting reference model.
module tb_cnn_layer_accel_fas_dout_wr;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_base_addr;
  logic [23:0] cfg_num_words;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] din;
  logic        wr_req;
  logic        wr_req_ack;
  logic [3:0]  wr_req_id;
  logic [3:0]  wr_req_fas_id;
  logic [31:0] wr_req_addr;
  logic [8:0]  wr_req_len;
  logic        wr_data_valid;
  logic        wr_data_ready;
  logic [31:0] wr_data;
  logic        wr_data_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  cnn_layer_accel_fas_dout_wr #(
    .C_FAS_ID(0), .C_SM_WR_ID(0), .C_DATA_WIDTH(32),
    .C_ADDR_WIDTH(32), .C_BURST_LEN(16), .C_FIFO_DEPTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .wr_req(wr_req), .wr_req_ack(wr_req_ack),
    .wr_req_id(wr_req_id), .wr_req_fas_id(wr_req_fas_id),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .wr_data(wr_data), .wr_data_last(wr_data_last),
    .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  int ack_delay = 0;
  int rdy_mode  = 0;
  int gap_mode  = 0;
  int req_wait  = 0;
  bit take      = 1'b0;

  logic [31:0] stim_q[$];
  logic [31:0] src_q[$];
  logic [31:0] got_addr[$];
  int          got_len[$];
  logic [31:0] got_data[$];
  bit          got_last[$];
  logic [31:0] exp_addr[$];
  int          exp_len[$];
  logic [31:0] exp_data[$];
  bit          exp_last[$];

  int done_cnt, underfill, max_buf, stall_seen, rdy_seen;
  int acc_n, beat_n, cyc, done_cyc, acc_cyc;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] w);
`ifdef CNN_LAYER_ACCEL_FAS_WR_RELU_EN
    if ($signed(w) < 0) return 32'd0;
`endif
    return w;
  endfunction

  task automatic clear_mon();
    got_addr.delete(); got_len.delete();
    got_data.delete(); got_last.delete();
    done_cnt = 0; underfill = 0; max_buf = 0;
    stall_seen = 0; rdy_seen = 0;
    acc_n = 0; beat_n = 0; done_cyc = -1;
  endtask

  // Observe handshakes mid-cycle; each one completes at the next posedge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (wr_req && (acc_n - beat_n) < int'(wr_req_len)) underfill++;
      if (acc_n - beat_n > max_buf) max_buf = acc_n - beat_n;
      if (acc_n - beat_n == 32 && din_valid && !din_ready) stall_seen++;
      if (din_ready) rdy_seen++;
      take = din_valid && din_ready;
      if (take) acc_n++;
      if (wr_req && wr_req_ack) begin
        got_addr.push_back(wr_req_addr);
        got_len.push_back(int'(wr_req_len));
      end
      if (wr_data_valid && wr_data_ready) begin
        got_data.push_back(wr_data);
        got_last.push_back(wr_data_last);
        beat_n++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      take = 1'b0;
    end
  end

  // Source, sink and request-acknowledge drivers.
  always @(posedge clk) begin
    #1;
    if (take && src_q.size() > 0) void'(src_q.pop_front());
    take = 1'b0;
    din_valid = (src_q.size() > 0) &&
                (gap_mode == 0 || $urandom_range(0, 3) != 0);
    din = (src_q.size() > 0) ? src_q[0] : 32'd0;
    case (rdy_mode)
      0:       wr_data_ready = 1'b1;
      1:       wr_data_ready = ~wr_data_ready;
      default: wr_data_ready = 1'($urandom_range(0, 1));
    endcase
    req_wait = (wr_req && rst) ? req_wait + 1 : 0;
    wr_req_ack = wr_req && (req_wait > ack_delay);
  end

  task automatic build_model(input logic [31:0] base, input int n);
    int off, len;
    exp_addr.delete(); exp_len.delete();
    exp_data.delete(); exp_last.delete();
    off = 0;
    while (off < n) begin
      len = (n - off < 16) ? n - off : 16;
      exp_addr.push_back(base + 32'(off * 4));
      exp_len.push_back(len);
      for (int k = 0; k < len; k++) begin
        exp_data.push_back(ref_word(stim_q[off + k]));
        exp_last.push_back(k == len - 1);
      end
      off += len;
    end
  endtask

  task automatic start_cfg(input logic [31:0] base, input int n,
                           input string tag);
    src_q = stim_q;
    clear_mon();
    @(posedge clk); #2;
    check({tag, " cfg_ready"}, cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_base_addr = base;
    cfg_num_words = 24'(n);
    @(posedge clk);
    acc_cyc = cyc;
    #2;
    cfg_valid = 1'b0;
  endtask

  task automatic run(input logic [31:0] base, input int n,
                     input string tag);
    int nr, nb;
    start_cfg(base, n, tag);
    for (int c = 0; c < 5000 && done_cnt == 0; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    build_model(base, n);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " req count"}, got_addr.size(), exp_addr.size());
    check({tag, " beat count"}, got_data.size(), exp_data.size());
    nr = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    nb = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < nr; i++) begin
      check($sformatf("%s req%0d addr", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s req%0d len", tag, i), got_len[i], exp_len[i]);
    end
    for (int i = 0; i < nb; i++) begin
      check($sformatf("%s beat%0d data", tag, i), got_data[i], exp_data[i]);
      check($sformatf("%s beat%0d last", tag, i), got_last[i], exp_last[i]);
    end
    check({tag, " words accepted"}, acc_n, n);
    check({tag, " excess left"}, src_q.size(), stim_q.size() - n);
    check({tag, " req before buffered"}, underfill, 0);
    check({tag, " idle busy"}, busy, 0);
    if (n == 0) begin
      check({tag, " done latency"}, done_cyc - acc_cyc, 1);
      check({tag, " din_ready seen"}, rdy_seen, 0);
    end
  endtask

  initial begin
    int n;
    logic [31:0] base;
    rst = 1'b0;
    cfg_valid = 1'b0;
    cfg_base_addr = '0;
    cfg_num_words = '0;
    din_valid = 1'b0;
    din = '0;
    wr_req_ack = 1'b0;
    wr_data_ready = 1'b0;
    cyc = 0;
    clear_mon();
    #12;
    check("rst cfg_ready", cfg_ready, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst wr_req", wr_req, 0);
    check("rst wr_data_valid", wr_data_valid, 0);
    check("rst din_ready", din_ready, 0);
    check("rst wr_req_len", wr_req_len, 0);
    #11 rst = 1'b1;

    stim_q.delete();
    for (int i = 0; i < 32; i++) stim_q.push_back(32'(i));
    run(32'h1000, 32, "two_bursts");

    stim_q.delete();
    for (int i = 0; i < 25; i++) stim_q.push_back($urandom);
    gap_mode = 1;
    run(32'h1000, 20, "short_tail");

    stim_q.delete();
    for (int i = 0; i < 48; i++) stim_q.push_back($urandom);
    gap_mode = 0; rdy_mode = 1; ack_delay = 5;
    run(32'h2000, 48, "backpressure");
    check("backpressure fifo peak", max_buf, 32);
    check("backpressure full stall", stall_seen > 0, 1);

    stim_q.delete();
    for (int i = 0; i < 3; i++) stim_q.push_back($urandom);
    rdy_mode = 0; ack_delay = 0;
    run(32'h3000, 0, "zero_words");

    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back(32'h100 + 32'(i));
    start_cfg(32'h4000, 16, "reset_mid");
    for (int c = 0; c < 2000 && beat_n < 7; c++) @(negedge clk);
    check("reset_mid reached beat 7", beat_n, 7);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("reset_mid cfg_ready", cfg_ready, 1);
    check("reset_mid busy", busy, 0);
    check("reset_mid wr_req", wr_req, 0);
    check("reset_mid wr_data_valid", wr_data_valid, 0);
    check("reset_mid wr_data", wr_data, 0);
    check("reset_mid wr_data_last", wr_data_last, 0);
    check("reset_mid din_ready", din_ready, 0);
    check("reset_mid done", done, 0);
    #30 rst = 1'b1;
    src_q.delete();
    clear_mon();
    repeat (5) @(posedge clk);
    #2;
    check("reset_mid no beats after", beat_n, 0);
    for (int i = 0; i < 16; i++) stim_q[i] = 32'h200 + 32'(i);
    run(32'h5000, 16, "after_reset");

    stim_q.delete();
    stim_q.push_back(32'hFFFF_FFFB);
    stim_q.push_back(32'h0000_0003);
    stim_q.push_back(32'hFFFF_FFFF);
    stim_q.push_back(32'h7FFF_FFFF);
    run(32'h6000, 4, "relu");

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 70);
      base = (r == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      stim_q.delete();
      for (int i = 0; i < n + int'($urandom_range(0, 3)); i++)
        stim_q.push_back($urandom);
      gap_mode = 1; rdy_mode = 2;
      ack_delay = $urandom_range(0, 4);
      run(base, n, $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
